mlu_operand_feeder: RTL and testbench
=====================================

# mlu_operand_feeder

Streams hot/cold operand rows from the HotBuf and ColdBuf SRAMs into the MLU, one 16-lane beat per cycle. It sits directly upstream of the MLU and walks a command of `n_cold` cold feature vectors, each `chunks` rows of 16 words, against one hot vector. Per beat it generates the MLU's `clear_reg_acc`, `is_output` and `index` sideband, so the accumulator resets at each vector start and emits at each vector end. Backpressure from the MLU controller is absorbed by a 2-entry skid buffer, so the 1-cycle SRAM latency never drops data.

## Interface
- `ADDR_W`, 10: SRAM row address width; all address arithmetic is modulo 2^ADDR_W.
- `LANES`, 16: words per row and per beat.
- `DW`, 32: word width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE; command accepted on `cmd_valid && cmd_ready`.
- `cmd_hot_base`  in  ADDR_W  first hot row.
- `cmd_cold_base`  in  ADDR_W  first cold row.
- `cmd_chunks`  in  8  rows per feature vector.
- `cmd_n_cold`  in  ADDR_W  cold vectors in the command.
- `hot_rd_en`, `hot_rd_addr`  out  1 / ADDR_W  HotBuf read request.
- `hot_rd_data`  in  LANES×DW  HotBuf data, valid 1 cycle after `hot_rd_en`.
- `cold_rd_en`, `cold_rd_addr`, `cold_rd_data`  same as hot, for ColdBuf.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  MLU controller accepts beat.
- `hot_out`, `cold_out`  out  LANES×DW  operands to MLU `hot_in` / `cold_in`.
- `clear_reg_acc`  out  1  beat is chunk 0 of a vector.
- `is_output`  out  1  beat is the last chunk of a vector.
- `index`  out  32  cold vector number j, zero-extended.
- `busy`  out  1  high from command accept until `done`.
- `done`  out  1  one-cycle pulse at command completion.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch the command and go to ISSUE. If `chunks`==0 or `n_cold`==0, go to FIN instead.
  - ISSUE: issue reads for beat (j, c), for j in 0..n_cold-1 and c in 0..chunks-1, c innermost.
    - Hot address = hot_base+c; cold address = cold_base+j·chunks+c, using a running cold pointer (no multiplier).
    - After issuing the last beat, go to DRAIN.
  - DRAIN: wait until no read is in flight and the skid buffer is empty, then go to FIN.
  - FIN: `done`=1 for exactly one cycle, then IDLE.
- A read is issued only when skid occupancy plus in-flight reads is less than 2. This guarantees capture space for every SRAM return.
- Hot reuse: when `chunks`==1, `hot_rd_en` asserts only for beat (0,0). The returned row is held in a hot register and reused for all later beats.
- Both SRAMs are read in the same cycle for every beat, except for the hot-reuse case above.
- Each captured beat carries {hot, cold, first=(c==0), last=(c==chunks-1), index=j}. `clear_reg_acc` and `is_output` are both high when `chunks`==1.
- Outputs are driven from the skid head. A beat is consumed on `out_valid && out_ready`.
- `rst` low in any state:
  - State returns to IDLE.
  - Counters, skid contents and in-flight tracking are discarded.
  - All outputs return to reset values on the next edge.
  - SRAM data returning after reset is ignored.

## Timing
- Reset values: `cmd_ready`=0 while `rst` is low and 1 in the first cycle after release. `out_valid`, `hot_rd_en`, `cold_rd_en`, `clear_reg_acc`, `is_output`, `busy` and `done` are 0. `index`, addresses, `hot_out` and `cold_out` are 0.
- Latency: accept at edge T, first read at T+1, first `out_valid` at T+2.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `done` pulses 1 cycle after the last beat handshake. For an empty command it pulses at T+1.
- `out_ready` low: `out_valid` and the beat hold stable. At most 2 beats are buffered, and reads stall after at most 1 more issue.
- Address wrap: hot_base+c and the cold pointer wrap silently at 2^ADDR_W.
- `cmd_valid` during `busy` is ignored; no queuing.

## Structure
- Shared package `mlu_pkg` holds the `LANES` and `DW` constants, the `mlu_beat_t` struct {hot, cold, first, last, index}, and the `feeder_state_t` enum {IDLE, ISSUE, DRAIN, FIN}.
- One sub-module, `mlu_beat_skid`: a 2-entry FIFO of `mlu_beat_t` with push, pop, count, head.

## Test plan
- chunks=2, n_cold=3, hot_base=0x10, cold_base=0x40, `out_ready`=1:
  - Expect 6 consecutive beats with cold addresses 0x40..0x45 and hot addresses 0x10, 0x11 repeating.
  - `clear_reg_acc` on beats 0, 2, 4; `is_output` on beats 1, 3, 5; index 0,0,1,1,2,2.
  - `done` one cycle after beat 5.
- chunks=1, n_cold=4: `hot_rd_en` asserts exactly once; 4 beats each with `clear_reg_acc`=`is_output`=1; `hot_out` is identical on all beats.
- chunks=3, n_cold=2 with `out_ready` toggling 1,0,0,1,…: all 6 beats delivered in order, none lost or duplicated, beats held stable while stalled.
- cold_base=0x3FE, chunks=4, n_cold=1: cold addresses 0x3FE, 0x3FF, 0x000, 0x001.
- n_cold=0: no `out_valid`; `done` at accept+1; `cmd_ready` high again at accept+2.
- `rst` dropped for one cycle mid-command (after beat 3 of 8): next cycle all outputs are 0 and state is IDLE; a new command then runs correctly from beat 0.

Source files
------------

// File: rtl/mlu_pkg.sv
// Shared types for the MLU operand path: row width, the per-beat record
// and the operand feeder state encoding.
package mlu_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int ROW_W = LANES * DW;

  typedef logic [ROW_W-1:0] row_t;

  typedef struct packed {
    row_t        hot;
    row_t        cold;
    logic        first;
    logic        last;
    logic [31:0] index;
  } mlu_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } feeder_state_t;

endpackage

// File: rtl/mlu_operand_feeder_if.sv
// Command, SRAM read and MLU beat signals of the operand feeder.
// The master modport is the feeder itself; slave is its surroundings.
interface mlu_operand_feeder_if
  import mlu_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_hot_base;
  logic [ADDR_W-1:0] cmd_cold_base;
  logic [7:0]        cmd_chunks;
  logic [ADDR_W-1:0] cmd_n_cold;

  logic              hot_rd_en;
  logic [ADDR_W-1:0] hot_rd_addr;
  row_t              hot_rd_data;
  logic              cold_rd_en;
  logic [ADDR_W-1:0] cold_rd_addr;
  row_t              cold_rd_data;

  logic              out_valid;
  logic              out_ready;
  row_t              hot_out;
  row_t              cold_out;
  logic              clear_reg_acc;
  logic              is_output;
  logic [31:0]       index;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_hot_base, cmd_cold_base, cmd_chunks, cmd_n_cold,
    input  hot_rd_data, cold_rd_data, out_ready,
    output cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
    output out_valid, hot_out, cold_out, clear_reg_acc, is_output, index,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_hot_base, cmd_cold_base, cmd_chunks, cmd_n_cold,
    output hot_rd_data, cold_rd_data, out_ready,
    input  cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
    input  out_valid, hot_out, cold_out, clear_reg_acc, is_output, index,
    input  busy, done
  );

endinterface

// File: rtl/mlu_beat_skid.sv
// Two-entry FIFO of MLU beats that absorbs SRAM returns while the MLU stalls.
// Callers never push when full or pop when empty.
module mlu_beat_skid
  import mlu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  mlu_beat_t  push_beat,
  input  logic       pop,
  output logic [1:0] count,
  output mlu_beat_t  head
);

  mlu_beat_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  // NOTE: sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: beat storage has no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_beat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mlu_operand_feeder.sv
// Walks a command of cold vectors against one hot vector, reading both
// SRAMs per beat and handing MLU beats with accumulate sideband downstream.
module mlu_operand_feeder
  import mlu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic                  clk,
  input logic                  rst,
  mlu_operand_feeder_if.master bus
);

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic              ready_en;
  logic [ADDR_W-1:0] hot_base;
  logic [ADDR_W-1:0] cold_ptr;
  logic [ADDR_W-1:0] n_cold;
  logic [ADDR_W-1:0] j_cnt;
  logic [7:0]        chunks;
  logic [7:0]        c_cnt;

  logic              pend;
  logic              pend_hot;
  logic              pend_first;
  logic              pend_last;
  logic [ADDR_W-1:0] pend_index;
  row_t              hot_reg;

  logic [1:0]        count;
  logic [1:0]        occ_next;
  mlu_beat_t         head;
  mlu_beat_t         push_beat;

  logic accept, issue, hot_issue, pop, out_valid;
  logic last_c, last_j, reuse, cmd_ready, done;

  assign reuse     = (chunks == 8'd1);
  assign last_c    = (c_cnt == chunks - 8'd1);
  assign last_j    = (j_cnt == n_cold - ADDR_W'(1));
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  // Skid occupancy once this cycle's return and pop settle; a new read
  // is only safe if that leaves room for its own return.
  assign occ_next  = count + 2'(pend) - 2'(pop);
  assign hot_issue = issue && (!reuse || (j_cnt == '0));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no latches.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ready_en;
        if (bus.cmd_valid && ready_en) begin
          accept     = 1'b1;
          state_next = (bus.cmd_chunks == 8'd0 || bus.cmd_n_cold == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        issue = (occ_next < 2'd2);
        if (issue && last_c && last_j) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pend && (count == 2'd0 || (count == 2'd1 && pop))) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      hot_base   <= '0;
      cold_ptr   <= '0;
      n_cold     <= '0;
      chunks     <= 8'd0;
      c_cnt      <= 8'd0;
      j_cnt      <= '0;
      pend       <= 1'b0;
      pend_hot   <= 1'b0;
      pend_first <= 1'b0;
      pend_last  <= 1'b0;
      pend_index <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        hot_base <= bus.cmd_hot_base;
        cold_ptr <= bus.cmd_cold_base;
        n_cold   <= bus.cmd_n_cold;
        chunks   <= bus.cmd_chunks;
        c_cnt    <= 8'd0;
        j_cnt    <= '0;
      end else if (issue) begin
        cold_ptr <= cold_ptr + ADDR_W'(1);
        if (last_c) begin
          c_cnt <= 8'd0;
          j_cnt <= j_cnt + ADDR_W'(1);
        end else begin
          c_cnt <= c_cnt + 8'd1;
        end
      end
      pend <= issue;
      if (issue) begin
        pend_hot   <= hot_issue;
        pend_first <= (c_cnt == 8'd0);
        pend_last  <= last_c;
        pend_index <= j_cnt;
      end
    end
  end

  // With one chunk per vector the single hot row is fetched once and reused.
  always_ff @(posedge clk) begin
    if (pend && pend_hot && reuse) hot_reg <= bus.hot_rd_data;
  end

  always_comb begin
    push_beat       = '0;
    push_beat.hot   = pend_hot ? bus.hot_rd_data : hot_reg;
    push_beat.cold  = bus.cold_rd_data;
    push_beat.first = pend_first;
    push_beat.last  = pend_last;
    push_beat.index = 32'(pend_index);
  end

  mlu_beat_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_beat (push_beat),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.cmd_ready     = cmd_ready;
  assign bus.done          = done;
  assign bus.busy          = (state != IDLE);
  assign bus.hot_rd_en     = hot_issue;
  assign bus.hot_rd_addr   = hot_base + ADDR_W'(c_cnt);
  assign bus.cold_rd_en    = issue;
  assign bus.cold_rd_addr  = cold_ptr;
  assign bus.out_valid     = out_valid;
  assign bus.hot_out       = out_valid ? head.hot   : '0;
  assign bus.cold_out      = out_valid ? head.cold  : '0;
  assign bus.clear_reg_acc = out_valid && head.first;
  assign bus.is_output     = out_valid && head.last;
  assign bus.index         = out_valid ? head.index : 32'd0;

endmodule

// File: tb/tb_mlu_operand_feeder.sv
// Directed bench for mlu_operand_feeder: SRAM models return address-tagged
// rows, a negedge monitor records reads, beats and done pulses.
module tb_mlu_operand_feeder;
  import mlu_pkg::*;

  localparam int AW = 10;

  typedef struct packed {
    row_t        hot;
    row_t        cold;
    logic        clr;
    logic        iso;
    logic [31:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mlu_operand_feeder_if #(.ADDR_W(AW)) bus ();
  mlu_operand_feeder #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic row_t hot_row(input logic [AW-1:0] a);
    row_t r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = 32'hA000_0000 | (32'(a) << 8) | 32'(l);
    return r;
  endfunction

  function automatic row_t cold_row(input logic [AW-1:0] a);
    row_t r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = 32'hC000_0000 | (32'(a) << 8) | 32'(l);
    return r;
  endfunction

  // Beat k of a command: j = k / chunks, c = k % chunks, cold row = cold_base + k.
  function automatic obs_t exp_beat(input logic [AW-1:0] hb, input logic [AW-1:0] cb,
                                    input int ch, input int k);
    obs_t e;
    int   j = k / ch;
    int   c = k % ch;
    e.hot  = hot_row(hb + AW'(c));
    e.cold = cold_row(cb + AW'(k));
    e.clr  = (c == 0);
    e.iso  = (c == ch - 1);
    e.idx  = 32'(j);
    return e;
  endfunction

  // SRAM models: rows valid one cycle after the read enable, junk otherwise.
  always @(posedge clk) begin
    bus.hot_rd_data  <= bus.hot_rd_en  ? hot_row(bus.hot_rd_addr)   : {LANES{32'hDEAD_BEEF}};
    bus.cold_rd_data <= bus.cold_rd_en ? cold_row(bus.cold_rd_addr) : {LANES{32'hDEAD_BEEF}};
  end

  logic [AW-1:0] hot_addrs[$];
  logic [AW-1:0] cold_addrs[$];
  obs_t          beats[$];
  int            beat_stamps[$];
  int            done_stamps[$];
  int            stab_err;
  int            stall_cnt;
  logic          stalled_prev;
  obs_t          prev_obs;

  always @(negedge clk) begin
    obs_t o;
    if (rst === 1'b1) begin
      o.hot = bus.hot_out;
      o.cold = bus.cold_out;
      o.clr = bus.clear_reg_acc;
      o.iso = bus.is_output;
      o.idx = bus.index;
      if (bus.hot_rd_en === 1'b1)  hot_addrs.push_back(bus.hot_rd_addr);
      if (bus.cold_rd_en === 1'b1) cold_addrs.push_back(bus.cold_rd_addr);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        beats.push_back(o);
        beat_stamps.push_back(cyc);
      end
      if (bus.done === 1'b1) done_stamps.push_back(cyc);
      if (stalled_prev && (bus.out_valid !== 1'b1 || o !== prev_obs)) stab_err++;
      stalled_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      if (stalled_prev) stall_cnt++;
      prev_obs = o;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] hb, input logic [AW-1:0] cb, input logic [7:0] ch,
                          input logic [AW-1:0] nc, output int t);
    hot_addrs.delete();
    cold_addrs.delete();
    beats.delete();
    beat_stamps.delete();
    done_stamps.delete();
    stab_err = 0;
    stall_cnt = 0;
    @(negedge clk);
    bus.cmd_hot_base  = hb;
    bus.cmd_cold_base = cb;
    bus.cmd_chunks    = ch;
    bus.cmd_n_cold    = nc;
    bus.cmd_valid     = 1'b1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready before accept: got %b want 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    t = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_stamps.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (done_stamps.size() == 0) begin
      errors++;
      $display("FAIL %s done timeout: got no done within %0d cycles, want one pulse", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset cmd_ready: got %b want 0", bus.cmd_ready);
    end
    checks++;
    if ({bus.out_valid, bus.hot_rd_en, bus.cold_rd_en, bus.clear_reg_acc, bus.is_output, bus.busy, bus.done} !== 7'b0) begin
      errors++;
      $display("FAIL reset controls: got %b want 0000000",
               {bus.out_valid, bus.hot_rd_en, bus.cold_rd_en, bus.clear_reg_acc, bus.is_output, bus.busy, bus.done});
    end
    checks++;
    if ({bus.index, bus.hot_rd_addr, bus.cold_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset index/addr: got %h/%h/%h want 0/0/0", bus.index, bus.hot_rd_addr, bus.cold_rd_addr);
    end
    checks++;
    if ({bus.hot_out, bus.cold_out} !== '0) begin
      errors++; $display("FAIL reset operands: got hot[31:0]=%h cold[31:0]=%h want 0", bus.hot_out[31:0], bus.cold_out[31:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset release cmd_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic();
    int   t;
    obs_t e;
    send_cmd(10'h010, 10'h040, 8'd2, 10'd3, t);
    wait_done("basic", 40);
    checks++;
    if (beats.size() != 6 || cold_addrs.size() != 6 || hot_addrs.size() != 6) begin
      errors++;
      $display("FAIL basic counts: got beats=%0d cold=%0d hot=%0d want 6/6/6", beats.size(), cold_addrs.size(), hot_addrs.size());
    end
    for (int k = 0; k < 6 && k < beats.size() && k < cold_addrs.size() && k < hot_addrs.size(); k++) begin
      e = exp_beat(10'h010, 10'h040, 2, k);
      checks++;
      if (beats[k] !== e || cold_addrs[k] !== 10'h040 + AW'(k) || hot_addrs[k] !== 10'h010 + AW'(k % 2)
          || beat_stamps[k] != t + 2 + k) begin
        errors++;
        $display("FAIL basic beat%0d: got idx=%0d clr=%b iso=%b hot=%h cold=%h ha=%h ca=%h at=%0d, want idx=%0d clr=%b iso=%b hot=%h cold=%h ha=%h ca=%h at=%0d",
                 k, beats[k].idx, beats[k].clr, beats[k].iso, beats[k].hot[31:0], beats[k].cold[31:0], hot_addrs[k], cold_addrs[k],
                 beat_stamps[k] - t, e.idx, e.clr, e.iso, e.hot[31:0], e.cold[31:0], 10'h010 + AW'(k % 2), 10'h040 + AW'(k), 2 + k);
      end
    end
    checks++;
    if (done_stamps.size() != 1 || done_stamps[0] != t + 8) begin
      errors++;
      $display("FAIL basic done timing: got %0d pulses first at +%0d, want 1 at +8", done_stamps.size(),
               done_stamps.size() > 0 ? done_stamps[0] - t : -1);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic back to idle: got ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_hot_reuse();
    int   t;
    obs_t e;
    send_cmd(10'h033, 10'h200, 8'd1, 10'd4, t);
    wait_done("hot_reuse", 40);
    checks++;
    if (hot_addrs.size() != 1 || hot_addrs[0] !== 10'h033) begin
      errors++;
      $display("FAIL hot_reuse reads: got %0d hot reads first=%h want 1 at 033", hot_addrs.size(),
               hot_addrs.size() > 0 ? hot_addrs[0] : 10'h0);
    end
    checks++;
    if (beats.size() != 4) begin
      errors++; $display("FAIL hot_reuse beat count: got %0d want 4", beats.size());
    end
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      e = exp_beat(10'h033, 10'h200, 1, k);
      checks++;
      if (beats[k] !== e || beats[k].hot !== beats[0].hot) begin
        errors++;
        $display("FAIL hot_reuse beat%0d: got idx=%0d clr=%b iso=%b hot=%h/%h cold=%h, want idx=%0d clr=1 iso=1 hot=%h cold=%h",
                 k, beats[k].idx, beats[k].clr, beats[k].iso, beats[k].hot[31:0], beats[k].hot[ROW_W-1 -: 32],
                 beats[k].cold[31:0], e.idx, e.hot[31:0], e.cold[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int         t;
    obs_t       e;
    logic [3:0] pat = 4'b1001;
    send_cmd(10'h020, 10'h100, 8'd3, 10'd2, t);
    for (int i = 0; i < 200 && done_stamps.size() == 0; i++) begin
      bus.out_ready = pat[i % 4];
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (done_stamps.size() == 0) begin
      errors++; $display("FAIL backpressure done timeout: got no done, want one pulse");
    end
    checks++;
    if (beats.size() != 6 || cold_addrs.size() != 6) begin
      errors++; $display("FAIL backpressure counts: got beats=%0d reads=%0d want 6/6", beats.size(), cold_addrs.size());
    end
    for (int k = 0; k < 6 && k < beats.size(); k++) begin
      e = exp_beat(10'h020, 10'h100, 3, k);
      checks++;
      if (beats[k] !== e) begin
        errors++;
        $display("FAIL backpressure beat%0d: got idx=%0d clr=%b iso=%b hot=%h cold=%h, want idx=%0d clr=%b iso=%b hot=%h cold=%h",
                 k, beats[k].idx, beats[k].clr, beats[k].iso, beats[k].hot[31:0], beats[k].cold[31:0],
                 e.idx, e.clr, e.iso, e.hot[31:0], e.cold[31:0]);
      end
    end
    checks++;
    if (stab_err != 0 || stall_cnt == 0) begin
      errors++; $display("FAIL backpressure hold: got %0d unstable of %0d stalled cycles, want 0 of >0", stab_err, stall_cnt);
    end
  endtask

  task automatic test_wrap();
    int            t;
    obs_t          e;
    logic [AW-1:0] exp_cold[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [AW-1:0] exp_hot[4]  = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
    send_cmd(10'h3FD, 10'h3FE, 8'd4, 10'd1, t);
    wait_done("wrap", 40);
    checks++;
    if (beats.size() != 4 || cold_addrs.size() != 4 || hot_addrs.size() != 4) begin
      errors++;
      $display("FAIL wrap counts: got beats=%0d cold=%0d hot=%0d want 4/4/4", beats.size(), cold_addrs.size(), hot_addrs.size());
    end
    for (int k = 0; k < 4 && k < beats.size() && k < cold_addrs.size() && k < hot_addrs.size(); k++) begin
      e = exp_beat(10'h3FD, 10'h3FE, 4, k);
      checks++;
      if (cold_addrs[k] !== exp_cold[k] || hot_addrs[k] !== exp_hot[k] || beats[k] !== e) begin
        errors++;
        $display("FAIL wrap beat%0d: got ca=%h ha=%h idx=%0d cold=%h, want ca=%h ha=%h idx=%0d cold=%h",
                 k, cold_addrs[k], hot_addrs[k], beats[k].idx, beats[k].cold[31:0], exp_cold[k], exp_hot[k], e.idx, e.cold[31:0]);
      end
    end
  endtask

  task automatic test_empty();
    int t;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) send_cmd(10'h000, 10'h000, 8'd3, 10'd0, t);
      else        send_cmd(10'h000, 10'h000, 8'd0, 10'd5, t);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL empty%0d done pulse: got done=%b valid=%b want 1/0", n, bus.done, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL empty%0d return: got ready=%b done=%b want 1/0", n, bus.cmd_ready, bus.done);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (beats.size() != 0 || cold_addrs.size() != 0 || hot_addrs.size() != 0 || done_stamps.size() != 1) begin
        errors++;
        $display("FAIL empty%0d activity: got beats=%0d reads=%0d/%0d dones=%0d want 0/0/0/1",
                 n, beats.size(), hot_addrs.size(), cold_addrs.size(), done_stamps.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int   t;
    obs_t e;
    send_cmd(10'h050, 10'h080, 8'd2, 10'd4, t);
    for (int i = 0; i < 40 && beats.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (beats.size() != 4) begin
      errors++; $display("FAIL reset_mid pre-beats: got %0d want 4", beats.size());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.out_valid, bus.hot_rd_en, bus.cold_rd_en, bus.clear_reg_acc, bus.is_output, bus.busy, bus.done} !== 8'b0
        || {bus.index, bus.hot_rd_addr, bus.cold_rd_addr} !== '0 || {bus.hot_out, bus.cold_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got ctl=%b idx=%h ha=%h ca=%h hot=%h want all 0",
               {bus.cmd_ready, bus.out_valid, bus.hot_rd_en, bus.cold_rd_en, bus.clear_reg_acc, bus.is_output, bus.busy, bus.done},
               bus.index, bus.hot_rd_addr, bus.cold_rd_addr, bus.hot_out[31:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid idle: got ready=%b valid=%b want 1/0", bus.cmd_ready, bus.out_valid);
    end
    send_cmd(10'h060, 10'h090, 8'd2, 10'd2, t);
    wait_done("reset_mid", 40);
    checks++;
    if (beats.size() != 4) begin
      errors++; $display("FAIL reset_mid rerun count: got %0d want 4", beats.size());
    end
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      e = exp_beat(10'h060, 10'h090, 2, k);
      checks++;
      if (beats[k] !== e || beat_stamps[k] != t + 2 + k) begin
        errors++;
        $display("FAIL reset_mid beat%0d: got idx=%0d clr=%b iso=%b cold=%h at=%0d, want idx=%0d clr=%b iso=%b cold=%h at=%0d",
                 k, beats[k].idx, beats[k].clr, beats[k].iso, beats[k].cold[31:0], beat_stamps[k] - t,
                 e.idx, e.clr, e.iso, e.cold[31:0], 2 + k);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_hot_base  = '0;
    bus.cmd_cold_base = '0;
    bus.cmd_chunks    = 8'd0;
    bus.cmd_n_cold    = '0;
    bus.out_ready     = 1'b1;
    stalled_prev      = 1'b0;
    stab_err          = 0;
    stall_cnt         = 0;
    test_reset();
    test_basic();
    test_hot_reuse();
    test_backpressure();
    test_wrap();
    test_empty();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
